instr_decode_queue: RTL and testbench

Registered, buffered instruction decode stage for the 16-bit CPU. It sits between instruction fetch and the register-file/ALU control. It accepts raw 16-bit instruction words over a valid/ready handshake and decodes them into class, opcode, register and immediate fields. Decoded bundles are held in a parametrised queue so fetch can run ahead of execute. Undefined encodings are flagged, and the whole queue is cleared by a branch/flush input.

---
 rtl/cpu_isa_pkg.sv | 40 ++++
 rtl/instr_decode_queue_if.sv | 31 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/instr_decode_queue.sv | 97 +++++++++
 tb/tb_instr_decode_queue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared 16-bit CPU ISA constants and the decoded-instruction bundle.
package cpu_isa_pkg;

  localparam logic [3:0] FT_WAIT    = 4'b0000;
  localparam logic [3:0] FT_RTYPE   = 4'b0001;
  localparam logic [3:0] FT_ITYPE   = 4'b0010;
  localparam logic [3:0] FT_LOAD    = 4'b0100;
  localparam logic [3:0] FT_STORE   = 4'b0101;
  localparam logic [3:0] FT_ILLEGAL = 4'b1111;

  localparam logic [7:0] OP_WAIT  = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOT   = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDU  = 8'h06;
  localparam logic [7:0] OP_ADDC  = 8'h07;
  localparam logic [7:0] OP_RSH   = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_ALSH  = 8'h0C;
  localparam logic [7:0] OP_ARSH  = 8'h0F;
  localparam logic [7:0] OP_LSH   = 8'h84;
  localparam logic [7:0] OP_LOAD  = 8'h85;
  localparam logic [7:0] OP_STORE = 8'h87;

  localparam logic [3:0] PFX_ADDI = 4'h5;
  localparam logic [3:0] PFX_SUBI = 4'h9;

  // Decoded fields except the immediate, whose width is a per-instance parameter.
  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] flag_type;
    logic [3:0] rdst;
    logic [3:0] rsrc;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for the decode queue.
interface instr_decode_queue_if #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      raw_instructions;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       opcode;
  logic [3:0]       flag_type;
  logic [3:0]       rdst;
  logic [3:0]       rsrc;
  logic [IMM_W-1:0] immediate;
  logic             illegal;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, raw_instructions, out_ready,
    input  in_ready, out_valid, opcode, flag_type, rdst, rsrc, immediate, illegal, count
  );

  modport slave (
    input  flush, in_valid, raw_instructions, out_ready,
    output in_ready, out_valid, opcode, flag_type, rdst, rsrc, immediate, illegal, count
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; the head register keeps its last value when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    // Head tracks the next-cycle read slot so it is already registered when valid.
    head_d = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign rd_data = head_q;
  assign count   = count_q;
endmodule

// File: rtl/instr_decode_queue.sv
// Decodes raw 16-bit instructions and buffers the decoded bundles for execute.
module instr_decode_queue
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned IMM_W    = 16,
  parameter bit          SEXT_IMM = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_decode_queue_if.slave  bus
);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned DEC_W   = $bits(dec_t);
  localparam int unsigned ENTRY_W = DEC_W + IMM_W;

  function automatic logic is_itype(input logic [15:0] ir);
    return (ir[15:12] == PFX_ADDI) || (ir[15:12] == PFX_SUBI);
  endfunction

  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d;
    d        = '0;
    d.opcode = ir[15:8];
    if (is_itype(ir)) begin
      d.opcode    = {4'h0, ir[15:12]};
      d.flag_type = FT_ITYPE;
      d.rdst      = ir[11:8];
    end else begin
      case (ir[15:8])
        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC,
        OP_RSH, OP_SUB, OP_CMP, OP_ALSH, OP_ARSH, OP_LSH: begin
          d.flag_type = FT_RTYPE;
          d.rdst      = ir[7:4];
          d.rsrc      = ir[3:0];
        end
        OP_LOAD, OP_STORE, OP_WAIT: begin
          d.flag_type = (ir[15:8] == OP_LOAD)  ? FT_LOAD  :
                        (ir[15:8] == OP_STORE) ? FT_STORE : FT_WAIT;
          d.rdst      = ir[7:4];
          d.rsrc      = ir[3:0];
        end
        default: begin
          d.flag_type = FT_ILLEGAL;
          d.illegal   = 1'b1;
        end
      endcase
    end
    return d;
  endfunction

  function automatic logic [IMM_W-1:0] decode_imm(input logic [15:0] ir);
    if (!is_itype(ir)) return '0;
    return SEXT_IMM ? IMM_W'($signed(ir[7:0])) : IMM_W'(ir[7:0]);
  endfunction

  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] wr_entry_c;
  logic [ENTRY_W-1:0] head;
  dec_t               head_dec;
  logic [IMM_W-1:0]   head_imm;
  logic               push_c;
  logic               pop_c;

  always_comb begin
    wr_entry_c = {decode(bus.raw_instructions), decode_imm(bus.raw_instructions)};
    push_c     = bus.in_valid & bus.in_ready & ~bus.flush;
    pop_c      = bus.out_valid & bus.out_ready & ~bus.flush;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (bus.flush),
    .wr_data (wr_entry_c),
    .rd_data (head),
    .count   (count)
  );

  assign {head_dec, head_imm} = head;

  // Handshake flags come only from the registered occupancy.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.count     = count;
  assign bus.opcode    = head_dec.opcode;
  assign bus.flag_type = head_dec.flag_type;
  assign bus.rdst      = head_dec.rdst;
  assign bus.rsrc      = head_dec.rsrc;
  assign bus.immediate = head_imm;
  assign bus.illegal   = head_dec.illegal & bus.out_valid;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (sign- and zero-extend instances).
module tb_instr_decode_queue;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  instr_decode_queue_if #(.IMM_W(16), .DEPTH(2)) bus_s ();
  instr_decode_queue_if #(.IMM_W(16), .DEPTH(2)) bus_z ();

  assign bus_z.flush            = bus_s.flush;
  assign bus_z.in_valid         = bus_s.in_valid;
  assign bus_z.raw_instructions = bus_s.raw_instructions;
  assign bus_z.out_ready        = bus_s.out_ready;

  instr_decode_queue #(.DEPTH(2), .IMM_W(16), .SEXT_IMM(1'b1)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  instr_decode_queue #(.DEPTH(2), .IMM_W(16), .SEXT_IMM(1'b0)) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_z.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic vld, input logic rdy,
                            input logic [1:0] cnt);
    chk({tag, ".out_valid"}, 32'(bus_s.out_valid), 32'(vld));
    chk({tag, ".in_ready"},  32'(bus_s.in_ready),  32'(rdy));
    chk({tag, ".count"},     32'(bus_s.count),     32'(cnt));
  endtask

  task automatic chk_head(input string tag, input logic [3:0] ft, input logic [7:0] opc,
                          input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm,
                          input logic ill);
    chk({tag, ".flag_type"}, 32'(bus_s.flag_type), 32'(ft));
    chk({tag, ".opcode"},    32'(bus_s.opcode),    32'(opc));
    chk({tag, ".rdst"},      32'(bus_s.rdst),      32'(rd));
    chk({tag, ".rsrc"},      32'(bus_s.rsrc),      32'(rs));
    chk({tag, ".immediate"}, 32'(bus_s.immediate), 32'(imm));
    chk({tag, ".illegal"},   32'(bus_s.illegal),   32'(ill));
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors                 = 0;
    checks                 = 0;
    reset                  = 1'b0;
    bus_s.flush            = 1'b0;
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h0512;
    bus_s.out_ready        = 1'b0;

    // Reset dominates an offered instruction
    step();
    step();
    chk_status("reset", 1'b0, 1'b1, 2'd0);
    chk_head("reset", 4'h0, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b0);

    reset          = 1'b1;
    bus_s.in_valid = 1'b0;
    step();
    chk_status("idle", 1'b0, 1'b1, 2'd0);

    // I-type ADDI, sign and zero extension
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h5AF0;
    step();
    bus_s.in_valid = 1'b0;
    chk_status("addi", 1'b1, 1'b1, 2'd1);
    chk_head("addi", 4'b0010, 8'h05, 4'hA, 4'h0, 16'hFFF0, 1'b0);
    chk("addi.zext_imm", 32'(bus_z.immediate), 32'h0000_00F0);

    // Pop to empty: data holds, illegal low
    bus_s.out_ready = 1'b1;
    step();
    bus_s.out_ready = 1'b0;
    chk_status("addi_pop", 1'b0, 1'b1, 2'd0);
    chk("addi_pop.hold_flag", 32'(bus_s.flag_type), 32'h2);
    chk("addi_pop.hold_imm",  32'(bus_s.immediate), 32'hFFF0);

    // SUBI with positive immediate
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h9305;
    bus_s.out_ready        = 1'b1;
    step();
    chk_head("subi", 4'b0010, 8'h09, 4'h3, 4'h0, 16'h0005, 1'b0);

    // Back-to-back R-type, load, store with continuous draining
    bus_s.raw_instructions = 16'h0534;
    step();
    chk_status("add", 1'b1, 1'b1, 2'd1);
    chk_head("add", 4'b0001, 8'h05, 4'h3, 4'h4, 16'h0000, 1'b0);
    bus_s.raw_instructions = 16'h8567;
    step();
    chk_status("load", 1'b1, 1'b1, 2'd1);
    chk_head("load", 4'b0100, 8'h85, 4'h6, 4'h7, 16'h0000, 1'b0);
    bus_s.raw_instructions = 16'h8789;
    step();
    chk_head("store", 4'b0101, 8'h87, 4'h8, 4'h9, 16'h0000, 1'b0);
    bus_s.raw_instructions = 16'h0012;
    step();
    chk_head("wait", 4'b0000, 8'h00, 4'h1, 4'h2, 16'h0000, 1'b0);
    bus_s.in_valid = 1'b0;
    step();
    chk_status("drain1", 1'b0, 1'b1, 2'd0);

    // Backpressure: third word stalls while full
    bus_s.out_ready        = 1'b0;
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h0112;
    step();
    chk_status("bp1", 1'b1, 1'b1, 2'd1);
    chk_head("bp1", 4'b0001, 8'h01, 4'h1, 4'h2, 16'h0000, 1'b0);
    bus_s.raw_instructions = 16'h0234;
    step();
    chk_status("bp2", 1'b1, 1'b0, 2'd2);
    chk("bp2.head", 32'(bus_s.opcode), 32'h01);
    bus_s.raw_instructions = 16'h0356;
    step();
    chk_status("bp3", 1'b1, 1'b0, 2'd2);
    chk("bp3.head", 32'(bus_s.opcode), 32'h01);

    // Full with pop still refuses the offered word
    bus_s.out_ready = 1'b1;
    step();
    chk_status("bp_pop1", 1'b1, 1'b1, 2'd1);
    chk_head("bp_pop1", 4'b0001, 8'h02, 4'h3, 4'h4, 16'h0000, 1'b0);
    step();
    bus_s.in_valid = 1'b0;
    chk_status("bp_pop2", 1'b1, 1'b1, 2'd1);
    chk_head("bp_pop2", 4'b0001, 8'h03, 4'h5, 4'h6, 16'h0000, 1'b0);
    step();
    chk_status("bp_drain", 1'b0, 1'b1, 2'd0);

    // Illegal encoding is queued and flagged
    bus_s.out_ready        = 1'b0;
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h0D12;
    step();
    chk_status("illegal", 1'b1, 1'b1, 2'd1);
    chk_head("illegal", 4'b1111, 8'h0D, 4'h0, 4'h0, 16'h0000, 1'b1);
    bus_s.raw_instructions = 16'h0112;
    step();
    chk_status("fill", 1'b1, 1'b0, 2'd2);

    // Flush with an offered word and out_ready high
    bus_s.flush            = 1'b1;
    bus_s.out_ready        = 1'b1;
    bus_s.raw_instructions = 16'h0934;
    step();
    bus_s.flush     = 1'b0;
    bus_s.in_valid  = 1'b0;
    bus_s.out_ready = 1'b0;
    chk_status("flush", 1'b0, 1'b1, 2'd0);
    chk("flush.illegal", 32'(bus_s.illegal), 32'h0);
    step();
    chk_status("flush_idle", 1'b0, 1'b1, 2'd0);

    // After flush, the next push appears alone at the head
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h0178;
    step();
    bus_s.in_valid = 1'b0;
    chk_status("post_flush", 1'b1, 1'b1, 2'd1);
    chk_head("post_flush", 4'b0001, 8'h01, 4'h7, 4'h8, 16'h0000, 1'b0);
    bus_s.out_ready = 1'b1;
    step();
    bus_s.out_ready = 1'b0;
    chk_status("post_flush_pop", 1'b0, 1'b1, 2'd0);

    // Mid-stream reset discards queued entries and clears data
    bus_s.in_valid         = 1'b1;
    bus_s.raw_instructions = 16'h5A7F;
    step();
    chk_status("pre_rst", 1'b1, 1'b1, 2'd1);
    reset = 1'b0;
    step();
    reset          = 1'b1;
    bus_s.in_valid = 1'b0;
    chk_status("mid_rst", 1'b0, 1'b1, 2'd0);
    chk_head("mid_rst", 4'h0, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
